des_search_sched: RTL
=====================

# des_search_sched

Sequencing controller for the DES brute-force key-search datapath. It owns the 56-bit candidate-key counter, issues one candidate per cycle into the parity-expand/DES/compare path, and tracks which in-flight candidates are valid across a configurable pipeline latency. It stops on the first ciphertext match or when the programmed key range is exhausted, and reports the winning 56-bit key and the number of keys evaluated. It replaces the free-running up-counter plus simple controller pairing at the top of the key-search design.

## Interface
- LAT, 1: cycles from `cand_key` being driven to its `match` result arriving (DES + result register); legal 1..16
- KW, 56: key width (without parity bits)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- Start  in  1  launch a search over [range_lo, range_hi]; level sampled per cycle
- Abort  in  1  cancel the current search; priority over Start
- range_lo  in  KW  first candidate key; sampled on accepted Start
- range_hi  in  KW  last candidate key, inclusive; sampled on accepted Start
- match  in  1  comparator result for the key issued LAT cycles earlier
- cand_key  out  KW  candidate key driven to the parity generator/DES
- issue  out  1  cand_key is a live candidate this cycle
- busy  out  1  state is RUN or DRAIN
- done  out  1  search finished (FOUND or EXHAUST); held
- found  out  1  done with a match
- found_key  out  KW  matching key; valid when found
- tried  out  KW+1  count of valid results evaluated, including the matching one

## Operation
- States: IDLE, RUN, DRAIN, FOUND, EXHAUST; reset state is IDLE.
- IDLE/FOUND/EXHAUST + Start (Abort low): capture range, clear tried, clear valid pipe.
  - If range_lo <= range_hi: go to RUN with cand_key = range_lo.
  - Otherwise: go to EXHAUST with tried = 0.
- RUN: issue = 1 each cycle. A valid shift register (depth LAT) and a key shift register (depth LAT) record each issue.
  - cand_key increments by 1 per cycle until it equals the captured range_hi.
  - The cycle in which range_hi is issued moves to DRAIN; cand_key holds at range_hi with no wrap.
- Result evaluation, in any state: when the valid tap (age LAT) is set, tried increments.
  - If match is also high, go to FOUND, found_key = key tap, and clear the valid pipe; later in-flight results are discarded.
  - match with the valid tap clear is ignored.
- DRAIN: issue = 0. Go to EXHAUST when the valid pipe is empty and no match occurred; a match during DRAIN goes to FOUND.
- Match and last issue in the same cycle: FOUND wins.
- FOUND/EXHAUST: done = 1, outputs held until a new Start. Start while busy is ignored.
- Abort (any state): go to IDLE and clear the valid pipe, done, and found. tried and found_key are retained.
- Reset values: state IDLE, cand_key 0, issue 0, busy 0, done 0, found 0, found_key 0, tried 0, valid pipe cleared.
- Arithmetic: tried is KW+1 bits, so the full range 0..2^56-1 yields tried = 2^56 with no overflow.

## Timing
- Start accepted at edge 0 → RUN in cycle 1, cand_key = range_lo, issue = 1.
- Key issued in cycle n has its match sampled in cycle n+LAT. A hit shows found/done from cycle n+LAT+1.
- Exhaust: last key issued in cycle k → done = 1, found = 0 from cycle k+LAT+1.
- All outputs are registered; issue and busy are decoded from the state register only.
- Asynchronous reset mid-search: all outputs go to reset values immediately. The first Start after reset is released behaves as a fresh search.

## Test plan
- Match mid-range: LAT=1, lo=0x10, hi=0x1F, match high in the cycle after 0x14 is issued → found=1, found_key=0x14, tried=5, done in cycle 7 after Start.
- Exhaust: LAT=3, lo=0x00, hi=0x07, match never set → issue for 8 cycles, done=1, found=0, tried=8 at cycle 8+3+1.
- Late match in DRAIN: LAT=4, lo=hi=0xABCD, match high 4 cycles after the issue → FOUND, found_key=0xABCD, tried=1. Repeat with match at 3 or 5 cycles → EXHAUST.
- Boundaries: lo=0xFFFFFFFFFFFFFE, hi=0xFFFFFFFFFFFFFF → two issues, no wrap, tried=2. Also lo=5, hi=4 → EXHAUST next cycle with tried=0, issue never asserted.
- Abort/Start priority: Abort and Start together during RUN → IDLE, done=0, issue=0. Start while busy → ignored, range unchanged.
- Reset: drive reset low mid-RUN, asynchronously between edges → all outputs at reset values before the next edge. Then Start → clean new search.

Source files
------------

// File: rtl/des_search_sched.sv
// des_search_sched: candidate-key sequencer for the DES brute-force key search.
// Walks a 56-bit key range one key per cycle, tracks in-flight candidates
// through a LAT-deep valid/key pipe, stops on first match or range end.
module des_search_sched #(
  parameter int LAT = 1,
  parameter int KW  = 56
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Start,
  input  logic          Abort,
  input  logic [KW-1:0] range_lo,
  input  logic [KW-1:0] range_hi,
  input  logic          match,
  output logic [KW-1:0] cand_key,
  output logic          issue,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic [KW-1:0] found_key,
  output logic [KW:0]   tried
);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_DRAIN, S_FOUND, S_EXHAUST
  } state_t;

  state_t                 state, state_nxt;
  logic [KW-1:0]          hi_q;
  logic [LAT-1:0]         vld_pipe;   // bit i: candidate of age i+1 is live
  logic [LAT-1:0][KW-1:0] key_pipe;   // key matching each vld_pipe bit
  logic [LAT-1:0]         vld_nxt;
  logic [LAT-1:0][KW-1:0] key_nxt;
  logic                   tap_vld, hit, start_ok, last_issue;

  // Outputs decode straight from the state register.
  assign issue = (state == S_RUN);
  assign busy  = (state == S_RUN) || (state == S_DRAIN);
  assign done  = (state == S_FOUND) || (state == S_EXHAUST);
  assign found = (state == S_FOUND);

  assign tap_vld    = vld_pipe[LAT-1];
  assign hit        = tap_vld & match;
  assign last_issue = (state == S_RUN) && (cand_key == hi_q);
  assign start_ok   = Start && !Abort &&
                      ((state == S_IDLE) || (state == S_FOUND) || (state == S_EXHAUST));

  // Pipe contents after one shift, with this cycle's issue entering at age 1.
  if (LAT == 1) begin : g_lat1
    assign vld_nxt = issue;
    assign key_nxt = cand_key;
  end else begin : g_latn
    assign vld_nxt = {vld_pipe[LAT-2:0], issue};
    assign key_nxt = {key_pipe[LAT-2:0], cand_key};
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: Abort first, then a match at the tap beats the last issue.
  always_comb begin
    state_nxt = state;
    if (Abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_FOUND, S_EXHAUST:
          if (Start) state_nxt = (range_lo <= range_hi) ? S_RUN : S_EXHAUST;
        S_RUN:
          if (hit)             state_nxt = S_FOUND;
          else if (last_issue) state_nxt = S_DRAIN;
        S_DRAIN:
          // Nothing younger than the tap remains: this is the final result.
          if (hit)                 state_nxt = S_FOUND;
          else if (vld_nxt == '0)  state_nxt = S_EXHAUST;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Key counter, in-flight pipes, result counter and winning key.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q      <= '0;
      cand_key  <= '0;
      vld_pipe  <= '0;
      key_pipe  <= '0;
      tried     <= '0;
      found_key <= '0;
    end else if (start_ok) begin
      hi_q     <= range_hi;
      cand_key <= range_lo;
      tried    <= '0;
      vld_pipe <= '0;
    end else if (Abort) begin
      vld_pipe <= '0;
    end else begin
      // A hit discards every younger candidate still in flight.
      vld_pipe <= hit ? '0 : vld_nxt;
      key_pipe <= key_nxt;
      if (tap_vld) tried <= tried + (KW+1)'(1);
      if (hit)     found_key <= key_pipe[LAT-1];
      if ((state == S_RUN) && !hit && (cand_key != hi_q))
        cand_key <= cand_key + KW'(1);
    end
  end

endmodule
